// File: rtl/neuromorphic_x1_ctrl.sv
// Host-to-ReRAM-macro command controller: single-cell writes/reads, EN sequencing,
// write-settle enforcement before reads, queue occupancy tracking and response strobe.
module neuromorphic_x1_ctrl #(
    parameter int WR_DLY      = 10,
    parameter int ACK_TIMEOUT = 4,
    parameter int RD_TIMEOUT  = 64,
    parameter int DEPTH       = 32
) (
    input  logic        CLKin,
    input  logic        RSTin,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [4:0]  cmd_row,
    input  logic [4:0]  cmd_col,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [5:0]  occupancy,
    output logic        EN,
    output logic        R_WB,
    output logic [31:0] DI,
    output logic [31:0] AD,
    output logic [3:0]  SEL,
    input  logic [31:0] DO,
    input  logic        func_ack
);

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_ACK, SETTLE, RD_REQ, RESP} state_t;

    state_t               state, state_nx;
    logic [4:0]           row_q, col_q;
    logic [7:0]           data_q;
    logic [5:0]           occ_q, pend_q;
    logic [15:0]          settle_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [7:0]           rdata_q;
    logic                 err_q;

    logic                 accept, wr_done, rd_done;
    logic                 resp_err_nx;
    logic [7:0]           resp_data_nx;
    logic                 unused_do;

    assign unused_do = ^DO[31:8];

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        wr_done      = 1'b0;
        rd_done      = 1'b0;
        resp_err_nx  = 1'b0;
        resp_data_nx = 8'h00;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_we) begin
                        if (occ_q == 6'(DEPTH)) begin
                            state_nx    = RESP;
                            resp_err_nx = 1'b1;
                        end else begin
                            state_nx = WR_REQ;
                        end
                    end else if (occ_q == 6'd0) begin
                        state_nx    = RESP;
                        resp_err_nx = 1'b1;
                    end else if (pend_q != 6'd0) begin
                        state_nx = SETTLE;
                    end else begin
                        state_nx = RD_REQ;
                    end
                end
            end
            WR_REQ: state_nx = WR_ACK;
            WR_ACK: begin
                if (func_ack) begin
                    state_nx = RESP;
                    wr_done  = 1'b1;
                end else if (timer_q == TIMER_W'(ACK_TIMEOUT)) begin
                    state_nx    = RESP;
                    resp_err_nx = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q <= 16'd1) begin
                    state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                if (func_ack) begin
                    state_nx     = RESP;
                    rd_done      = 1'b1;
                    resp_data_nx = DO[7:0];
                end else if (timer_q == TIMER_W'(RD_TIMEOUT)) begin
                    state_nx    = RESP;
                    resp_err_nx = 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Timers restart at 1 on every state change so expiry compares directly with the limit.
    always_ff @(posedge CLKin) begin
        if (!RSTin) begin
            state    <= IDLE;
            row_q    <= 5'd0;
            col_q    <= 5'd0;
            data_q   <= 8'd0;
            occ_q    <= 6'd0;
            pend_q   <= 6'd0;
            settle_q <= 16'd0;
            timer_q  <= '0;
            rdata_q  <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                timer_q <= TIMER_W'(1);
            end else if (state == WR_ACK || state == RD_REQ) begin
                timer_q <= timer_q + TIMER_W'(1);
            end
            if (accept) begin
                row_q    <= cmd_row;
                col_q    <= cmd_col;
                data_q   <= cmd_data;
                settle_q <= 16'(WR_DLY * int'(pend_q));
            end else if (state == SETTLE) begin
                settle_q <= settle_q - 16'd1;
            end
            if (state == SETTLE && state_nx == RD_REQ) begin
                pend_q <= 6'd0;
            end else if (wr_done && pend_q != 6'(DEPTH)) begin
                pend_q <= pend_q + 6'd1;
            end
            if (wr_done) begin
                occ_q <= occ_q + 6'd1;
            end else if (rd_done) begin
                occ_q <= occ_q - 6'd1;
            end
            if (state_nx == RESP && state != RESP) begin
                err_q   <= resp_err_nx;
                rdata_q <= resp_data_nx;
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign EN        = (state == WR_REQ) || (state == RD_REQ);
    assign R_WB      = (state == RD_REQ);
    assign SEL       = EN ? 4'hF : 4'h0;
    assign DI        = EN ? {2'b00, row_q, col_q, 12'h000, data_q} : 32'h0;
    assign AD        = EN ? {22'h0, row_q, col_q} : 32'h0;
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err_q;
    assign rsp_data  = (state == RESP) ? rdata_q : 8'h00;
    assign occupancy = occ_q;

endmodule

// File: doc/neuromorphic_x1_ctrl.md
# neuromorphic_x1_ctrl

Initiator-side controller driving the 32x32 ReRAM macro command port (EN/R_WB/DI/AD/SEL, DO/func_ack). Accepts single-cell write/read commands from a host valid/ready interface, packs them into macro DI format, sequences EN timing, enforces write-settle time before reads, tracks macro queue occupancy, and returns read data or error on a one-cycle response strobe. Sits between the user-project bus bridge and the macro.

## Interface
- WR_DLY, 10: macro settle cycles required per pending write before the next read.
- ACK_TIMEOUT, 4: max cycles to wait for func_ack after a write request.
- RD_TIMEOUT, 64: max cycles EN is held for a read before abort.
- DEPTH, 32: macro queue depth.

Ports (clock and reset first):
- CLKin  input  1  clock; all logic on rising edge.
- RSTin  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  high only in IDLE.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_row  input  5  cell row.
- cmd_col  input  5  cell column.
- cmd_data  input  8  write data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_data  output  8  read data; 0 for writes and errors.
- rsp_err  output  1  qualified by rsp_valid.
- occupancy  output  6  outstanding writes not yet read back (0..DEPTH).
- EN  output  1  macro enable.
- R_WB  output  1  1 = read, 0 = write.
- DI  output  32  {2'b00, row, col, 12'h000, data}.
- AD  output  32  {22'h0, row, col}.
- SEL  output  4  4'hF while EN high, else 4'h0.
- DO  input  32  macro read data; bits [7:0] used.
- func_ack  input  1  macro acknowledge.

## Operation
- Reset (RSTin low at posedge): state IDLE; EN, R_WB, rsp_valid, rsp_err = 0; DI, AD, rsp_data = 0; SEL = 0; occupancy = 0; pending-write counter = 0; timers = 0. Reset mid-operation drops EN on that edge, abandons the command, emits no response.
- Command latched on cmd_valid && cmd_ready; all fields registered at acceptance.
- States: IDLE, WR_REQ, WR_ACK, SETTLE, RD_REQ, RESP.
- IDLE: write with occupancy==DEPTH, or read with occupancy==0 -> RESP with rsp_err=1, no macro access. Write otherwise -> WR_REQ. Read with pending>0 -> SETTLE; pending==0 -> RD_REQ.
- WR_REQ: EN=1, R_WB=0, DI/AD/SEL driven for exactly one cycle -> WR_ACK.
- WR_ACK: EN=0. func_ack=1 -> occupancy+1, pending+1 (saturate at DEPTH), RESP ok. ACK_TIMEOUT cycles without ack -> RESP err, counters unchanged.
- SETTLE: EN=0 for exactly WR_DLY*pending cycles (16-bit down-counter), then pending=0 -> RD_REQ.
- RD_REQ: EN=1, R_WB=1 held. func_ack=1 -> capture DO[7:0], EN=0 next edge, occupancy-1, RESP ok. RD_TIMEOUT cycles without ack -> EN=0, RESP err, occupancy unchanged.
- RESP: rsp_valid=1 one cycle with rsp_data/rsp_err -> IDLE. No response backpressure.
- Reads return data in macro FIFO order (oldest written cell); controller does not reorder.
- func_ack outside WR_ACK/RD_REQ ignored.

## Timing
- cmd_ready is combinational from state (IDLE only); acceptance edge T.
- Write: EN high in cycle T+1 only; ack typically sampled T+2; rsp_valid at T+3. Minimum write-to-write spacing 4 cycles.
- Read, no pending: EN rises T+1, stays high through the cycle func_ack is sampled high (macro RD_Dly 44 -> ack about T+46); rsp_valid the following cycle.
- Read after n writes: EN low WR_DLY*n cycles after T before EN rises.
- Error on full/empty: rsp_valid at T+1, EN never asserted.
- Timeout counters count cycles in state starting at 1; expiry on count==limit.

## Test plan
- Reset: hold RSTin low 3 cycles while cmd_valid=1 -> all outputs 0, cmd_ready high first cycle after release, no EN pulse.
- Write row 3 col 5 data 0xA5 -> single-cycle EN with R_WB=0, DI=0x06500 0A5 (0x065000A5), AD=0x65, rsp_err=0, occupancy=1.
- Two writes then read -> EN low exactly 20 cycles after read acceptance, then EN=1/R_WB=1 until ack; rsp_data equals first write's data, occupancy=1.
- Read with occupancy 0 -> rsp_valid with rsp_err=1 one cycle after acceptance, EN stays 0.
- 32 writes then a 33rd -> 33rd errors, occupancy stays 32; macro tied to never ack on read -> EN drops after 64 cycles, rsp_err=1, occupancy unchanged.
- Assert RSTin low while in RD_REQ -> EN=0 on that edge, no rsp_valid, occupancy=0.
